// File: rtl/bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter
//
// Two-digit BCD up/down counter (00-99). A prescaler turns the system clock
// into a count tick every TICK_DIV cycles while running. Two debounced
// push-buttons are synchronized and edge-detected: start toggles RUN/STOP,
// clear zeroes the count. Digits feed a seven-segment decoder directly, so
// they are presented as 5-bit codes with bit 4 held at 0.
//
// Parameters
//   TICK_DIV   clk cycles per count step (>= 2)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous, active-high reset
//   btn_start  in   start/stop button (asynchronous level, active-high)
//   btn_clear  in   clear button (asynchronous level, active-high)
//   dir_up     in   1 = count up, 0 = count down (sampled on the tick cycle)
//   ones       out  ones digit 0-9
//   tens       out  tens digit 0-9
//   running    out  1 while in RUN
//   wrap       out  one-cycle pulse on 99->00 (up) or 00->99 (down)
//
// Button events are single-cycle strobes: a level going high before edge k
// is applied at edge k+2. All outputs come straight from flops.
// ---------------------------------------------------------------------------
module bcd_updown_counter #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       dir_up,
    output logic [4:0] ones,
    output logic [4:0] tens,
    output logic       running,
    output logic       wrap
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Button conditioning flops
    logic start_s1_q, start_s1_d;
    logic start_s2_q, start_s2_d;
    logic start_prev_q, start_prev_d;
    logic clear_s1_q, clear_s1_d;
    logic clear_s2_q, clear_s2_d;
    logic clear_prev_q, clear_prev_d;

    // Counts the cycles after reset until the synchronizer and edge
    // registers hold real input history. Until then a button that was held
    // through reset would look like a fresh rising edge, so events are masked.
    logic [1:0] warm_q, warm_d;
    logic       inputs_ready;

    // FSM and datapath flops
    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [3:0]     ones_q, ones_d;
    logic [3:0]     tens_q, tens_d;
    logic           wrap_q, wrap_d;

    logic start_evt;
    logic clear_evt;
    logic tick;

    // -----------------------------------------------------------------------
    // Input conditioning: 2-FF synchronizer + rising-edge detector
    // -----------------------------------------------------------------------
    always_comb begin
        start_s1_d   = btn_start;
        start_s2_d   = start_s1_q;
        start_prev_d = start_s2_q;
        clear_s1_d   = btn_clear;
        clear_s2_d   = clear_s1_q;
        clear_prev_d = clear_s2_q;
        warm_d       = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    end

    assign inputs_ready = (warm_q == 2'd3);
    assign start_evt    = start_s2_q & ~start_prev_q & inputs_ready;
    assign clear_evt    = clear_s2_q & ~clear_prev_q & inputs_ready;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (start_evt) begin
            state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
        end
    end

    // FSM: outputs
    always_comb begin
        running = (state_q == ST_RUN);
    end

    // -----------------------------------------------------------------------
    // Prescaler and digit datapath
    // -----------------------------------------------------------------------
    assign tick = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

    always_comb begin
        presc_d = presc_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        wrap_d  = 1'b0;

        // Any start event (either direction) or clear restarts the prescaler,
        // so the first tick after entering RUN is a full TICK_DIV away.
        if ((state_q != ST_RUN) || start_evt || clear_evt) begin
            presc_d = '0;
        end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        if (clear_evt) begin
            // Clear beats a coincident tick: no step, no wrap.
            ones_d = 4'd0;
            tens_d = 4'd0;
        end else if (tick && !start_evt) begin
            if (dir_up) begin
                if (ones_q == 4'd9) begin
                    ones_d = 4'd0;
                    if (tens_q == 4'd9) begin
                        tens_d = 4'd0;
                        wrap_d = 1'b1;
                    end else begin
                        tens_d = tens_q + 4'd1;
                    end
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end else begin
                if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    if (tens_q == 4'd0) begin
                        tens_d = 4'd9;
                        wrap_d = 1'b1;
                    end else begin
                        tens_d = tens_q - 4'd1;
                    end
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Datapath and conditioning registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            start_s1_q   <= 1'b0;
            start_s2_q   <= 1'b0;
            start_prev_q <= 1'b0;
            clear_s1_q   <= 1'b0;
            clear_s2_q   <= 1'b0;
            clear_prev_q <= 1'b0;
            warm_q       <= 2'd0;
            presc_q      <= '0;
            ones_q       <= 4'd0;
            tens_q       <= 4'd0;
            wrap_q       <= 1'b0;
        end else begin
            start_s1_q   <= start_s1_d;
            start_s2_q   <= start_s2_d;
            start_prev_q <= start_prev_d;
            clear_s1_q   <= clear_s1_d;
            clear_s2_q   <= clear_s2_d;
            clear_prev_q <= clear_prev_d;
            warm_q       <= warm_d;
            presc_q      <= presc_d;
            ones_q       <= ones_d;
            tens_q       <= tens_d;
            wrap_q       <= wrap_d;
        end
    end

    assign ones = {1'b0, ones_q};
    assign tens = {1'b0, tens_q};
    assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Testbench for bcd_updown_counter with TICK_DIV = 4.
// Inputs are driven 1 ns after a rising edge and outputs sampled at the same
// point, so every sample is well away from the active edge.
module tb_bcd_updown_counter;

    localparam int TICK_DIV = 4;

    logic       clk;
    logic       rst;
    logic       btn_start;
    logic       btn_clear;
    logic       dir_up;
    logic [4:0] ones;
    logic [4:0] tens;
    logic       running;
    logic       wrap;

    bcd_updown_counter #(.TICK_DIV(TICK_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .dir_up    (dir_up),
        .ones      (ones),
        .tens      (tens),
        .running   (running),
        .wrap      (wrap)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    // Expected record: {tens[3:0], ones[3:0], running, wrap}
    logic [9:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       do_start;
        logic       do_clear;
        logic       dir;
        int         wait_n;
        logic [3:0] e_tens;
        logic [3:0] e_ones;
        logic       e_run;
        logic       e_wrap;
    } vec_t;

    vec_t vecs[8];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle pulse on the selected buttons; returns just after the edge
    // where the event takes effect.
    task automatic press(input logic s, input logic c);
        btn_start = s;
        btn_clear = c;
        step(1);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        step(2);
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] t, input logic [3:0] o,
                            input logic r, input logic w);
        exp_q.push_back({t, o, r, w});
    endtask

    task automatic compare_out(input string tag);
        logic [9:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s_queue: got empty queue, expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_tens"},    tens,           {1'b0, e[9:6]});
            check({tag, "_ones"},    ones,           {1'b0, e[5:2]});
            check({tag, "_running"}, {4'b0, running}, {4'b0, e[1]});
            check({tag, "_wrap"},    {4'b0, wrap},    {4'b0, e[0]});
        end
    endtask

    task automatic expect_now(input string tag, input logic [3:0] t, input logic [3:0] o,
                              input logic r, input logic w);
        push_exp(t, o, r, w);
        compare_out(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Sequence from STOP at 00 with a zero prescaler.
        //            start clear dir  wait  tens  ones  run   wrap
        vecs[0] = '{1'b1, 1'b0, 1'b1, 0,   4'd0, 4'd0, 1'b1, 1'b0}; // start, up
        vecs[1] = '{1'b0, 1'b0, 1'b1, 48,  4'd1, 4'd2, 1'b1, 1'b0}; // 12 ticks
        vecs[2] = '{1'b0, 1'b1, 1'b1, 0,   4'd0, 4'd0, 1'b1, 1'b0}; // clear, keeps running
        vecs[3] = '{1'b0, 1'b0, 1'b1, 392, 4'd9, 4'd8, 1'b1, 1'b0}; // 98 ticks
        vecs[4] = '{1'b0, 1'b0, 1'b1, 4,   4'd9, 4'd9, 1'b1, 1'b0}; // 99
        vecs[5] = '{1'b0, 1'b0, 1'b1, 3,   4'd9, 4'd9, 1'b1, 1'b0}; // just before wrap
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1,   4'd0, 4'd0, 1'b1, 1'b1}; // 99 -> 00 wrap
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1,   4'd0, 4'd0, 1'b1, 1'b0}; // wrap is one cycle

        // T1: reset with both buttons held
        rst       = 1'b1;
        btn_start = 1'b1;
        btn_clear = 1'b1;
        dir_up    = 1'b1;
        step(2);
        expect_now("reset", 4'd0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step(6);
        expect_now("held_after_reset", 4'd0, 4'd0, 1'b0, 1'b0);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        step(3);

        // T2/T3: table-driven up count and up wrap
        for (int i = 0; i < 8; i++) begin
            dir_up = vecs[i].dir;
            if (vecs[i].do_start || vecs[i].do_clear) begin
                press(vecs[i].do_start, vecs[i].do_clear);
            end
            if (vecs[i].wait_n > 0) begin
                step(vecs[i].wait_n);
            end
            push_exp(vecs[i].e_tens, vecs[i].e_ones, vecs[i].e_run, vecs[i].e_wrap);
            compare_out($sformatf("v%0d", i));
        end

        // T5a: clear lands on a tick edge; a down step would give 99 + wrap
        dir_up = 1'b0;
        press(1'b0, 1'b1);
        expect_now("clear_on_tick", 4'd0, 4'd0, 1'b1, 1'b0);

        // T4: down wrap then one more step
        step(4);
        expect_now("down_wrap", 4'd9, 4'd9, 1'b1, 1'b1);
        step(1);
        expect_now("down_wrap_end", 4'd9, 4'd9, 1'b1, 1'b0);
        step(3);
        expect_now("down_98", 4'd9, 4'd8, 1'b1, 1'b0);

        // T5b: start event on the tick edge stops without stepping
        step(1);
        press(1'b1, 1'b0);
        expect_now("start_on_tick", 4'd9, 4'd8, 1'b0, 1'b0);

        // T6: stopped for 40 cycles
        for (int k = 0; k < 4; k++) begin
            step(10);
            expect_now($sformatf("stop_%0d", k), 4'd9, 4'd8, 1'b0, 1'b0);
        end

        // T6: held start gives one toggle; counting down resumes
        btn_start = 1'b1;
        step(20);
        expect_now("hold_start", 4'd9, 4'd4, 1'b1, 1'b0);
        btn_start = 1'b0;
        step(5);
        expect_now("hold_release", 4'd9, 4'd3, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
